// File: rtl/jdec_dequant.sv
// JPEG decoder dequantizer: multiplies zigzag coefficient pairs by the quant table, de-zigzags into a
// ping-pong block buffer and streams raster-order pairs out. Optional q_cnt checking: JDEC_DEQUANT_SEQ_CHECK_EN.
module jdec_dequant #(
  parameter int QW = 11,
  parameter int OW = 16,
  parameter int TW = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic signed [QW-1:0] q [2],
  input  logic                 q_valid,
  output logic                 q_hold,
  input  logic [4:0]           q_cnt,
  input  logic [1:0]           q_chroma,
  input  logic                 q_last_mcu,
  output logic signed [OW-1:0] d [2],
  output logic                 d_valid,
  input  logic                 d_hold,
  output logic [4:0]           d_cnt,
  output logic [1:0]           d_chroma,
  output logic                 d_last_mcu,
  input  logic                 tbl_we,
  input  logic [6:0]           tbl_addr,
  input  logic [TW-1:0]        tbl_data,
  output logic                 seq_err
);

  localparam int PW = QW + TW + 1;
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  // natural (raster) position of each zigzag index
  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  typedef enum logic [1:0] {BK_EMPTY, BK_FILLING, BK_FULL, BK_READING} bank_st_t;

  logic [TW-1:0]        tbl_mem  [128];
  logic signed [OW-1:0] bank_mem [2][64];

  bank_st_t bank_st_q [2], bank_st_d [2];
  logic [1:0] bank_chroma_q [2], bank_chroma_d [2];
  logic bank_last_q [2], bank_last_d [2];

  logic wr_bank_q, wr_bank_d, wr_mid_q, wr_mid_d, q_hold_q, q_hold_d;
  logic [1:0] cur_chroma_q, cur_chroma_d;

  logic p_valid_q, p_valid_d, p_bank_q, p_bank_d, p_last_q, p_last_d;
  logic [4:0] p_cnt_q, p_cnt_d;
  logic signed [OW-1:0] p_prod_q [2], p_prod_d [2];

  logic rd_bank_q, rd_bank_d, d_valid_q, d_valid_d;
  logic [4:0] d_cnt_q, d_cnt_d;
  logic [1:0] d_chroma_q, d_chroma_d;
  logic d_last_q, d_last_d;
  logic signed [OW-1:0] d_q [2], d_d [2];

  logic accept, eff_first, tbl_sel;
  logic [4:0] eff_cnt;
  logic [TW-1:0] entry [2];
  logic signed [PW-1:0] qx [2], ex [2], prod [2];
  logic rd_ld, rd_start, rd_ld_bank;
  logic [4:0] rd_ld_cnt;

  assign accept = q_valid & ~q_hold_q;

`ifdef JDEC_DEQUANT_SEQ_CHECK_EN
  logic [4:0] exp_cnt_q, exp_cnt_d;
  logic seq_err_q, seq_err_d;

  // the locally tracked count addresses the bank; the received count is only compared
  assign eff_cnt = exp_cnt_q;
  assign seq_err = seq_err_q;

  always_comb begin
    exp_cnt_d = exp_cnt_q;
    seq_err_d = seq_err_q;
    if (accept) begin
      exp_cnt_d = exp_cnt_q + 5'd1;
      if (q_cnt != exp_cnt_q) seq_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      exp_cnt_q <= '0;
      seq_err_q <= 1'b0;
    end else begin
      exp_cnt_q <= exp_cnt_d;
      seq_err_q <= seq_err_d;
    end
  end
`else
  assign eff_cnt = q_cnt;
  assign seq_err = 1'b0;
`endif

  assign eff_first = (eff_cnt == 5'd0);
  // the block's chroma tag is only presented with pair 0, so that pair uses the live input
  assign tbl_sel   = eff_first ? (q_chroma != 2'd0) : (cur_chroma_q != 2'd0);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      entry[i] = tbl_mem[{tbl_sel, eff_cnt, 1'(i)}];
      qx[i]    = {{(PW-QW){q[i][QW-1]}}, q[i]};
      ex[i]    = {{(PW-TW){1'b0}}, entry[i]};
      prod[i]  = qx[i] * ex[i];
      if (prod[i] > SAT_MAX)      p_prod_d[i] = SAT_MAX[OW-1:0];
      else if (prod[i] < SAT_MIN) p_prod_d[i] = SAT_MIN[OW-1:0];
      else                        p_prod_d[i] = prod[i][OW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) tbl_mem[tbl_addr] <= tbl_data;
    if (p_valid_q) begin
      bank_mem[p_bank_q][ZZ[{p_cnt_q, 1'b0}]] <= p_prod_q[0];
      bank_mem[p_bank_q][ZZ[{p_cnt_q, 1'b1}]] <= p_prod_q[1];
    end
  end

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_st_d[b]     = bank_st_q[b];
      bank_chroma_d[b] = bank_chroma_q[b];
      bank_last_d[b]   = bank_last_q[b];
    end
    wr_bank_d    = wr_bank_q;
    wr_mid_d     = wr_mid_q;
    cur_chroma_d = cur_chroma_q;
    p_valid_d    = accept;
    p_bank_d     = wr_bank_q;
    p_cnt_d      = eff_cnt;
    p_last_d     = (eff_cnt == 5'd31);
    rd_bank_d    = rd_bank_q;
    d_valid_d    = d_valid_q;
    d_cnt_d      = d_cnt_q;
    d_chroma_d   = d_chroma_q;
    d_last_d     = d_last_q;
    d_d[0]       = d_q[0];
    d_d[1]       = d_q[1];
    rd_ld        = 1'b0;
    rd_start     = 1'b0;
    rd_ld_bank   = rd_bank_q;
    rd_ld_cnt    = '0;

    if (accept) begin
      if (bank_st_q[wr_bank_q] == BK_EMPTY) bank_st_d[wr_bank_q] = BK_FILLING;
      if (eff_first) begin
        bank_chroma_d[wr_bank_q] = q_chroma;
        bank_last_d[wr_bank_q]   = q_last_mcu;
        cur_chroma_d             = q_chroma;
      end
      wr_mid_d = (eff_cnt != 5'd31);
      if (eff_cnt == 5'd31) wr_bank_d = ~wr_bank_q;
    end
    if (p_valid_q && p_last_q) bank_st_d[p_bank_q] = BK_FULL;

    if (d_valid_q && !d_hold) begin
      if (d_cnt_q == 5'd31) begin
        bank_st_d[rd_bank_q] = BK_EMPTY;
        rd_bank_d            = ~rd_bank_q;
        d_cnt_d              = '0;
        if (bank_st_q[~rd_bank_q] == BK_FULL) begin
          rd_ld      = 1'b1;
          rd_start   = 1'b1;
          rd_ld_bank = ~rd_bank_q;
        end else begin
          d_valid_d = 1'b0;
        end
      end else begin
        rd_ld     = 1'b1;
        rd_ld_cnt = d_cnt_q + 5'd1;
        d_cnt_d   = d_cnt_q + 5'd1;
      end
    end else if (!d_valid_q && bank_st_q[rd_bank_q] == BK_FULL) begin
      rd_ld    = 1'b1;
      rd_start = 1'b1;
    end

    if (rd_start) begin
      bank_st_d[rd_ld_bank] = BK_READING;
      d_valid_d             = 1'b1;
      d_chroma_d            = bank_chroma_q[rd_ld_bank];
      d_last_d              = bank_last_q[rd_ld_bank];
    end
    if (rd_ld) begin
      d_d[0] = bank_mem[rd_ld_bank][{rd_ld_cnt, 1'b0}];
      d_d[1] = bank_mem[rd_ld_bank][{rd_ld_cnt, 1'b1}];
    end

    // stall only at a block boundary, and only while the next bank is still occupied
    q_hold_d = ~wr_mid_d & (bank_st_d[wr_bank_d] != BK_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int b = 0; b < 2; b++) begin
        bank_st_q[b]     <= BK_EMPTY;
        bank_chroma_q[b] <= '0;
        bank_last_q[b]   <= 1'b0;
        p_prod_q[b]      <= '0;
        d_q[b]           <= '0;
      end
      wr_bank_q    <= 1'b0;
      wr_mid_q     <= 1'b0;
      q_hold_q     <= 1'b0;
      cur_chroma_q <= '0;
      p_valid_q    <= 1'b0;
      p_bank_q     <= 1'b0;
      p_last_q     <= 1'b0;
      p_cnt_q      <= '0;
      rd_bank_q    <= 1'b0;
      d_valid_q    <= 1'b0;
      d_cnt_q      <= '0;
      d_chroma_q   <= '0;
      d_last_q     <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        bank_st_q[b]     <= bank_st_d[b];
        bank_chroma_q[b] <= bank_chroma_d[b];
        bank_last_q[b]   <= bank_last_d[b];
        p_prod_q[b]      <= p_prod_d[b];
        d_q[b]           <= d_d[b];
      end
      wr_bank_q    <= wr_bank_d;
      wr_mid_q     <= wr_mid_d;
      q_hold_q     <= q_hold_d;
      cur_chroma_q <= cur_chroma_d;
      p_valid_q    <= p_valid_d;
      p_bank_q     <= p_bank_d;
      p_last_q     <= p_last_d;
      p_cnt_q      <= p_cnt_d;
      rd_bank_q    <= rd_bank_d;
      d_valid_q    <= d_valid_d;
      d_cnt_q      <= d_cnt_d;
      d_chroma_q   <= d_chroma_d;
      d_last_q     <= d_last_d;
    end
  end

  assign q_hold     = q_hold_q;
  assign d[0]       = d_q[0];
  assign d[1]       = d_q[1];
  assign d_valid    = d_valid_q;
  assign d_cnt      = d_cnt_q;
  assign d_chroma   = d_chroma_q;
  assign d_last_mcu = d_last_q;

endmodule

// File: tb/tb_jdec_dequant.sv
// Directed bench for jdec_dequant: a block-level model (dequantize, saturate, raster reorder) feeds an
// expected-pair queue that one compare process checks every valid output cycle.
module tb_jdec_dequant;
  localparam int QW = 11;
  localparam int OW = 16;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic signed [QW-1:0] q_in [2];
  logic q_valid, q_hold, q_last_mcu;
  logic [4:0] q_cnt;
  logic [1:0] q_chroma;
  logic signed [OW-1:0] d_out [2];
  logic d_valid, d_hold, d_last_mcu;
  logic [4:0] d_cnt;
  logic [1:0] d_chroma;
  logic tbl_we;
  logic [6:0] tbl_addr;
  logic [TW-1:0] tbl_data;
  logic seq_err;

  jdec_dequant #(.QW(QW), .OW(OW), .TW(TW)) dut (
    .clk(clk), .resetn(resetn),
    .q(q_in), .q_valid(q_valid), .q_hold(q_hold), .q_cnt(q_cnt),
    .q_chroma(q_chroma), .q_last_mcu(q_last_mcu),
    .d(d_out), .d_valid(d_valid), .d_hold(d_hold), .d_cnt(d_cnt),
    .d_chroma(d_chroma), .d_last_mcu(d_last_mcu),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .seq_err(seq_err)
  );

  typedef struct {
    int d0;
    int d1;
    int cnt;
    int chroma;
    int last;
  } pair_t;

  pair_t exp_q [$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_acc = 0;
  int tbl_m [128];
  int zz [64];
  int blk [64];
  int cap_d0 [512], cap_d1 [512], cap_ch [512], cap_last [512], cap_cnt [512], cap_cyc [512];
  int cap_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // zigzag order walks the anti-diagonals, alternating direction
  function automatic void gen_zigzag();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + (s - r); k++; end
      end
    end
  endfunction

  task automatic model_block(input int chroma, input int last);
    int nat [64];
    int base = (chroma != 0) ? 64 : 0;
    for (int k = 0; k < 64; k++) nat[zz[k]] = sat(blk[k] * tbl_m[base + k]);
    for (int p = 0; p < 32; p++) begin
      pair_t e;
      e.d0 = nat[2*p]; e.d1 = nat[2*p+1]; e.cnt = p; e.chroma = chroma; e.last = last;
      exp_q.push_back(e);
    end
  endtask

  task automatic wr_tbl(input int addr, input int data);
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = 7'(addr); tbl_data = TW'(data);
    tbl_m[addr] = data;
  endtask

  task automatic tbl_idle();
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic send_pair(input int cnt, input int c0, input int c1, input int chroma, input int last);
    int n = 0;
    @(negedge clk);
    q_valid = 1'b1; q_cnt = 5'(cnt); q_in[0] = QW'(c0); q_in[1] = QW'(c1);
    q_chroma = 2'(chroma); q_last_mcu = (last != 0);
    while (q_hold && n < 300) begin @(negedge clk); n++; end
    check("q_accept", int'(q_hold), 0);
    t_acc = cyc;
  endtask

  task automatic idle_in();
    @(negedge clk);
    q_valid = 1'b0;
  endtask

  task automatic send_block(input int chroma, input int last, input int gap);
    model_block(chroma, last);
    for (int p = 0; p < 32; p++) begin
      if (gap > 0 && (p % gap) == gap - 1) begin @(negedge clk); q_valid = 1'b0; end
      send_pair(p, blk[2*p], blk[2*p+1], chroma, last);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || d_valid) && n < 1000) begin @(negedge clk); n++; end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    pair_t e;
    #1;
    if (resetn && d_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output: d_valid=1 d_cnt=%0d with no pair expected", d_cnt);
      end else begin
        e = exp_q[0];
        check("d0", int'(d_out[0]), e.d0);
        check("d1", int'(d_out[1]), e.d1);
        check("d_cnt", int'(d_cnt), e.cnt);
        check("d_chroma", int'(d_chroma), e.chroma);
        check("d_last_mcu", int'(d_last_mcu), e.last);
        if (!d_hold) begin
          if (cap_n < 512) begin
            cap_d0[cap_n] = int'(d_out[0]); cap_d1[cap_n] = int'(d_out[1]);
            cap_ch[cap_n] = int'(d_chroma); cap_last[cap_n] = int'(d_last_mcu);
            cap_cnt[cap_n] = int'(d_cnt); cap_cyc[cap_n] = cyc;
            cap_n++;
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int n;
    gen_zigzag();
    q_valid = 1'b0; q_cnt = '0; q_in[0] = '0; q_in[1] = '0; q_chroma = '0; q_last_mcu = 1'b0;
    d_hold = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_q_hold", int'(q_hold), 0);
    check("rst_d_valid", int'(d_valid), 0);
    check("rst_d_cnt", int'(d_cnt), 0);
    check("rst_d_chroma", int'(d_chroma), 0);
    check("rst_d_last_mcu", int'(d_last_mcu), 0);
    check("rst_seq_err", int'(seq_err), 0);
    resetn = 1'b1;

    // ramp block through a unity luma table; chroma table set to 3 so misuse shows
    for (int a = 0; a < 64; a++) wr_tbl(a, 1);
    for (int a = 64; a < 128; a++) wr_tbl(a, 3);
    tbl_idle();
    for (int k = 0; k < 64; k++) blk[k] = k;
    b = cap_n;
    send_block(0, 0, 0);
    idle_in();
    n = 0;
    while (!d_valid && n < 20) begin @(negedge clk); n++; end
    check("first_valid_latency", cyc - t_acc, 3);
    check("first_valid_d_cnt", int'(d_cnt), 0);
    wait_drain();
    check("ramp_p0_d0", cap_d0[b], 0);
    check("ramp_p0_d1", cap_d1[b], 1);
    check("ramp_p1_d0", cap_d0[b+1], 5);
    check("ramp_p1_d1", cap_d1[b+1], 6);
    check("ramp_p4_d0", cap_d0[b+4], 2);
    check("ramp_p4_d1", cap_d1[b+4], 4);
    check("ramp_p31_d0", cap_d0[b+31], 62);
    check("ramp_p31_d1", cap_d1[b+31], 63);
    check("ramp_chroma", cap_ch[b], 0);

    // chroma DC through table 1
    wr_tbl(64, 16);
    tbl_idle();
    for (int k = 0; k < 64; k++) blk[k] = (k % 7) - 3;
    blk[0] = -7;
    b = cap_n;
    send_block(1, 0, 0);
    idle_in();
    wait_drain();
    check("chroma_dc", cap_d0[b], -112);
    check("chroma_nat1", cap_d1[b], -6);
    check("chroma_tag", cap_ch[b], 1);
    check("chroma_cnt0", cap_cnt[b], 0);

    // saturation both ways
    wr_tbl(0, 255);
    wr_tbl(1, 255);
    tbl_idle();
    for (int k = 0; k < 64; k++) blk[k] = k % 3;
    blk[0] = 1023; blk[1] = -1024;
    b = cap_n;
    send_block(0, 1, 0);
    idle_in();
    wait_drain();
    check("sat_pos", cap_d0[b], 32767);
    check("sat_neg", cap_d1[b], -32768);
    check("sat_last_tag", cap_last[b], 1);

    // three blocks against a stalled consumer
    @(negedge clk);
    d_hold = 1'b1;
    b = cap_n;
    for (int k = 0; k < 64; k++) blk[k] = k - 32;
    send_block(0, 0, 0);
    for (int k = 0; k < 64; k++) blk[k] = 2 * k - 60;
    send_block(1, 0, 0);
    idle_in();
    check("hold_after_two", int'(q_hold), 1);
    check("held_valid", int'(d_valid), 1);
    check("held_cnt", int'(d_cnt), 0);
    for (int k = 0; k < 64; k++) blk[k] = 100 - k;
    fork
      begin
        send_block(2, 1, 0);
        idle_in();
      end
      begin
        repeat (10) @(negedge clk);
        check("hold_still_high", int'(q_hold), 1);
        d_hold = 1'b0;
      end
    join
    wait_drain();
    check("three_block_count", cap_n - b, 96);
    check("blkA_tag", cap_ch[b], 0);
    check("blkB_tag", cap_ch[b+32], 1);
    check("blkC_tag", cap_ch[b+64], 2);
    check("blkB_last", cap_last[b+32], 0);
    check("blkC_last", cap_last[b+64], 1);
    check("blkC_cnt0", cap_cnt[b+64], 0);
    check("ab_no_bubble", cap_cyc[b+32] - cap_cyc[b+31], 1);

    // reset in the middle of a block, then a block with input gaps
    for (int k = 0; k < 64; k++) blk[k] = k + 1;
    for (int p = 0; p <= 17; p++) send_pair(p, blk[2*p], blk[2*p+1], 0, 0);
    @(negedge clk);
    q_valid = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    check("midrst_q_hold", int'(q_hold), 0);
    check("midrst_d_valid", int'(d_valid), 0);
    for (int k = 0; k < 64; k++) blk[k] = 3 * k - 90;
    b = cap_n;
    send_block(0, 0, 3);
    idle_in();
    wait_drain();
    check("midrst_count", cap_n - b, 32);
    check("midrst_cnt0", cap_cnt[b], 0);
    check("midrst_d0", cap_d0[b], -22950);
    check("midrst_d1", cap_d1[b], -22185);

`ifdef JDEC_DEQUANT_SEQ_CHECK_EN
    for (int k = 0; k < 64; k++) blk[k] = k - 20;
    model_block(0, 0);
    send_pair(0, blk[0], blk[1], 0, 0);
    send_pair(1, blk[2], blk[3], 0, 0);
    check("seq_err_before", int'(seq_err), 0);
    send_pair(3, blk[4], blk[5], 0, 0);
    idle_in();
    check("seq_err_set", int'(seq_err), 1);
    for (int p = 3; p < 32; p++) send_pair(p, blk[2*p], blk[2*p+1], 0, 0);
    idle_in();
    wait_drain();
    for (int k = 0; k < 64; k++) blk[k] = 5 - k;
    send_block(0, 0, 0);
    idle_in();
    wait_drain();
    check("seq_err_sticky", int'(seq_err), 1);
`else
    check("seq_err_tied", int'(seq_err), 0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
